maze_memory: RTL and testbench

MAZE_MEMORY -- requirements
Module: maze_memory

---
 rtl/maze_memory_pkg.sv | 19 +
 rtl/maze_row_ram.sv | 38 +++
 rtl/maze_memory.sv | 144 ++++++++++++++
 tb/tb_maze_memory.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_memory_pkg.sv
// Shared definitions for the maze cell store:
// FSM encoding, default geometry and cell values.
package maze_memory_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    READY,
    RESTORING
  } state_t;

  localparam int ROWS_DEF = 16;
  localparam int COLS_DEF = 16;
  localparam int IDX_W    = 4;

  localparam logic WALL = 1'b1;
  localparam logic FREE = 1'b0;

endpackage

// File: rtl/maze_row_ram.sv
// ROWS x COLS bit array: row write/read port plus one
// addressed cell port; out-of-range cells read as wall.
module maze_row_ram
  import maze_memory_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             row_we,
  input  logic [IDX_W-1:0] row_sel,
  input  logic [COLS-1:0]  row_wdata,
  output logic [COLS-1:0]  row_rdata,
  input  logic             bit_we,
  input  logic [IDX_W-1:0] bx,
  input  logic [IDX_W-1:0] by,
  input  logic             bit_wdata,
  output logic             bit_rdata
);

  logic [COLS-1:0] mem [ROWS];
  logic            in_rng;

  assign in_rng = (int'(bx) < COLS) && (int'(by) < ROWS);
  assign bit_rdata = in_rng ? mem[by][bx] : WALL;
  assign row_rdata = mem[row_sel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= '1;
    end else begin
      if (row_we) mem[row_sel] <= row_wdata;
      if (bit_we && in_rng) mem[by][bx] <= bit_wdata;
    end
  end

endmodule

// File: rtl/maze_memory.sv
// Maze cell store: working copy for RD/WR plus a pristine
// shadow copy that restore streams back one row per cycle.
module maze_memory
  import maze_memory_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] X,
  input  logic [IDX_W-1:0] Y,
  input  logic             RD,
  input  logic             WR,
  input  logic             D_in,
  output logic             D_out,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [COLS-1:0]  load_row,
  input  logic             restore,
  output logic             busy,
  output logic             loaded
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROWS - 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] row_cnt, row_nx;
  logic             ready;
  logic             work_row_we, shadow_row_we;
  logic [COLS-1:0]  work_row_wdata, shadow_row;
  logic [COLS-1:0]  work_row_unused;
  logic             work_bit, shadow_bit_unused;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      row_cnt <= '0;
    end else begin
      state   <= state_nx;
      row_cnt <= row_nx;
    end
  end

  always_comb begin
    state_nx = state;
    row_nx   = row_cnt;
    unique case (state)
      EMPTY: begin
        if (load_start) begin
          state_nx = LOADING;
          row_nx   = '0;
        end
      end
      LOADING: begin
        if (load_valid) begin
          row_nx = row_cnt + 1'b1;
          if (row_cnt == LAST) state_nx = READY;
        end
      end
      READY: begin
        if (load_start) begin
          state_nx = LOADING;
          row_nx   = '0;
        end else if (restore) begin
          state_nx = RESTORING;
          row_nx   = '0;
        end
      end
      RESTORING: begin
        row_nx = row_cnt + 1'b1;
        if (row_cnt == LAST) state_nx = READY;
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    busy           = 1'b0;
    loaded         = 1'b0;
    ready          = 1'b0;
    work_row_we    = 1'b0;
    shadow_row_we  = 1'b0;
    work_row_wdata = load_row;
    unique case (state)
      LOADING: begin
        busy          = 1'b1;
        work_row_we   = load_valid;
        shadow_row_we = load_valid;
      end
      READY: begin
        loaded = 1'b1;
        ready  = 1'b1;
      end
      RESTORING: begin
        busy           = 1'b1;
        loaded         = 1'b1;
        work_row_we    = 1'b1;
        work_row_wdata = shadow_row;
      end
      default: ;
    endcase
  end

  // read samples the pre-write cell; any access while not ready reads wall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      D_out <= WALL;
    end else if (ready) begin
      if (RD) D_out <= work_bit;
    end else if (RD || WR) begin
      D_out <= WALL;
    end
  end

  maze_row_ram #(.ROWS(ROWS), .COLS(COLS)) u_work (
    .clk       (clk),
    .rst       (rst),
    .row_we    (work_row_we),
    .row_sel   (row_cnt),
    .row_wdata (work_row_wdata),
    .row_rdata (work_row_unused),
    .bit_we    (ready && WR),
    .bx        (X),
    .by        (Y),
    .bit_wdata (D_in),
    .bit_rdata (work_bit)
  );

  maze_row_ram #(.ROWS(ROWS), .COLS(COLS)) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .row_we    (shadow_row_we),
    .row_sel   (row_cnt),
    .row_wdata (load_row),
    .row_rdata (shadow_row),
    .bit_we    (1'b0),
    .bx        (X),
    .by        (Y),
    .bit_wdata (1'b0),
    .bit_rdata (shadow_bit_unused)
  );

endmodule

// File: tb/tb_maze_memory.sv
// Bench for maze_memory: array-level reference model checked
// every cycle, plus directed scenarios with literal results.
module tb_maze_memory;

  localparam int M_EMPTY = 0;
  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  X = '0;
  logic [3:0]  Y = '0;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic        D_in = 1'b0;
  logic        D_out;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_row = '0;
  logic        restore = 1'b0;
  logic        busy;
  logic        loaded;

  int n_cmp = 0;
  int n_bad = 0;

  maze_memory dut (
    .clk        (clk),
    .rst        (rst),
    .X          (X),
    .Y          (Y),
    .RD         (RD),
    .WR         (WR),
    .D_in       (D_in),
    .D_out      (D_out),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_row   (load_row),
    .restore    (restore),
    .busy       (busy),
    .loaded     (loaded)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string n, input logic a, input logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b at %0t", n, a, e, $time);
    end
  endtask

  task automatic chkn(input string n, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask

  // reference model: whole-array view, restore modelled as an
  // instant copy followed by a busy window of 16 cycles
  logic [15:0] wk [16];
  logic [15:0] sh [16];
  int          m_mode;
  int          m_cnt;
  int          m_cd;
  logic        m_dout;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = M_EMPTY;
      m_cnt  = 0;
      m_cd   = 0;
      m_dout = 1'b1;
      for (int r = 0; r < 16; r++) begin
        wk[r] = '1;
        sh[r] = '1;
      end
    end else if (m_cd > 0) begin
      if (RD || WR) m_dout = 1'b1;
      m_cd--;
    end else begin
      if (m_mode == M_READY) begin
        if (RD) m_dout = wk[Y][X];
        if (WR) wk[Y][X] = D_in;
      end else if (RD || WR) begin
        m_dout = 1'b1;
      end
      case (m_mode)
        M_EMPTY: if (load_start) begin
          m_mode = M_LOAD;
          m_cnt  = 0;
        end
        M_LOAD: if (load_valid) begin
          wk[m_cnt] = load_row;
          sh[m_cnt] = load_row;
          m_cnt++;
          if (m_cnt == 16) m_mode = M_READY;
        end
        M_READY: begin
          if (load_start) begin
            m_mode = M_LOAD;
            m_cnt  = 0;
          end else if (restore) begin
            for (int r = 0; r < 16; r++) wk[r] = sh[r];
            m_cd = 16;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk1("model_d_out", D_out, m_dout);
      chk1("model_busy", busy, (m_mode == M_LOAD) || (m_cd > 0));
      chk1("model_loaded", loaded, m_mode == M_READY);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] pat(input int sel, input int k);
    logic [15:0] one;
    one = 16'h0001;
    return (sel == 0) ? 16'hFFFE : (one << k);
  endfunction

  task automatic rdc(input logic [3:0] x, input logic [3:0] y,
                     input logic e, input string n);
    X = x;
    Y = y;
    RD = 1'b1;
    tick();
    RD = 1'b0;
    chk1(n, D_out, e);
  endtask

  task automatic wr(input logic [3:0] x, input logic [3:0] y,
                    input logic d);
    X = x;
    Y = y;
    D_in = d;
    WR = 1'b1;
    tick();
    WR = 1'b0;
  endtask

  task automatic do_load(input int sel, input int gap,
                         input bit with_rst, input bit poke,
                         input int nrows);
    load_start = 1'b1;
    restore = with_rst;
    tick();
    load_start = 1'b0;
    restore = 1'b0;
    chk1("load_busy", busy, 1'b1);
    chk1("load_not_loaded", loaded, 1'b0);
    for (int k = 0; k < nrows; k++) begin
      for (int g = 0; g < gap; g++) begin
        load_start = poke && (g == 0) && (k == 4);
        tick();
        load_start = 1'b0;
      end
      load_row = pat(sel, k);
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      if (k == 14) chk1("loaded_after_15", loaded, 1'b0);
      if (k == 15) chk1("loaded_after_16", loaded, 1'b1);
      if (k == 15) chk1("busy_after_16", busy, 1'b0);
    end
  endtask

  int n;

  initial begin
    repeat (3) tick();
    chk1("rst_d_out", D_out, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_loaded", loaded, 1'b0);
    rst = 1'b1;
    tick();

    rdc(4'd2, 4'd2, 1'b1, "rd_unloaded");
    wr(4'd1, 4'd0, 1'b0);

    do_load(0, 0, 1'b0, 1'b0, 16);
    rdc(4'd0, 4'd0, 1'b0, "rd_0_0");
    rdc(4'd1, 4'd0, 1'b1, "rd_1_0_prewr_dropped");

    wr(4'd0, 4'd3, 1'b1);
    rdc(4'd0, 4'd3, 1'b1, "rd_0_3_marked");
    restore = 1'b1;
    tick();
    restore = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    chkn("restore_busy_cycles", n, 16);
    rdc(4'd0, 4'd3, 1'b0, "rd_0_3_restored");

    X = 4'd0;
    Y = 4'd5;
    D_in = 1'b1;
    RD = 1'b1;
    WR = 1'b1;
    tick();
    RD = 1'b0;
    WR = 1'b0;
    chk1("rdwr_prewrite", D_out, 1'b0);
    rdc(4'd0, 4'd5, 1'b1, "rd_after_rdwr");

    do_load(1, 3, 1'b1, 1'b1, 16);
    rdc(4'd5, 4'd5, 1'b1, "gap_5_5");
    rdc(4'd6, 4'd5, 1'b0, "gap_6_5");
    rdc(4'd15, 4'd15, 1'b1, "gap_15_15");
    rdc(4'd0, 4'd15, 1'b0, "gap_0_15");

    do_load(0, 0, 1'b0, 1'b0, 7);
    rst = 1'b0;
    #2;
    chk1("midload_rst_loaded", loaded, 1'b0);
    chk1("midload_rst_busy", busy, 1'b0);
    chk1("midload_rst_d_out", D_out, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    restore = 1'b1;
    tick();
    restore = 1'b0;
    chk1("restore_in_empty", busy, 1'b0);
    rdc(4'd6, 4'd5, 1'b1, "rd_after_rst");
    do_load(0, 0, 1'b0, 1'b0, 16);
    rdc(4'd0, 4'd0, 1'b0, "reload_0_0");
    rdc(4'd4, 4'd9, 1'b1, "reload_4_9");
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
